// File: rtl/vending_controller.sv
// vending_controller: main sequencing FSM of the vending machine.
// Locks the selected price, accumulates coins, drives the dispense actuator,
// then returns change, or refunds the full credit on cancel.
// Optional feature macro: VENDING_CONTROLLER_TIMEOUT_EN (auto-refund after
// TIMEOUT_CYCLES idle cycles in COLLECT).
// Ports:
//   clk, reset      clock (rising edge), synchronous active-high reset
//   product_sel     keypad code 00 none, 01 A, 10 B, 11 C
//   selected_price  price from product_selection, 0 = none
//   coin_valid      one-cycle coin strobe; coin_code 01=5 10=10 11=20 00=invalid
//   cancel          user cancel level
//   credit          accumulated credit
//   dispense        actuator drive, dispense_id = product latched at selection
//   change_valid    one-cycle strobe qualifying change_amt
//   refund          change_valid is a full refund; timeout: refund was timeout-caused
//   coin_reject     one-cycle strobe, last coin returned unaccepted
//   state           IDLE=0 COLLECT=1 DISPENSE=2 CHANGE=3 REFUND=4
module vending_controller #(
    parameter int PRICE_W         = 5,
    parameter int CREDIT_W        = 6,
    parameter int DISPENSE_CYCLES = 2,
    parameter int TIMEOUT_CYCLES  = 1000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          product_sel,
    input  logic [PRICE_W-1:0]  selected_price,
    input  logic                coin_valid,
    input  logic [1:0]          coin_code,
    input  logic                cancel,
    output logic [CREDIT_W-1:0] credit,
    output logic                dispense,
    output logic [1:0]          dispense_id,
    output logic                change_valid,
    output logic [CREDIT_W-1:0] change_amt,
    output logic                refund,
    output logic                coin_reject,
    output logic                timeout,
    output logic [2:0]          state
);
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        COLLECT  = 3'd1,
        DISPENSE = 3'd2,
        CHANGE   = 3'd3,
        REFUND   = 3'd4
    } state_t;

    localparam int DW = DISPENSE_CYCLES > 1 ? $clog2(DISPENSE_CYCLES) : 1;

    state_t              cur, nxt;
    logic [PRICE_W-1:0]  price_reg;
    logic [CREDIT_W-1:0] price_ext, coin_val, sum, credit_nxt;
    logic [DW-1:0]       dcnt;
    logic                coin_ok, rej, tmo, tmo_hit, pay;

    assign state     = cur;
    assign price_ext = CREDIT_W'(price_reg);
    assign coin_ok   = coin_valid && coin_code != 2'b00;
    assign coin_val  = coin_code == 2'b01 ? CREDIT_W'(5)  :
                       coin_code == 2'b10 ? CREDIT_W'(10) :
                       coin_code == 2'b11 ? CREDIT_W'(20) : '0;
    assign sum       = credit + (coin_ok ? coin_val : '0);

`ifdef VENDING_CONTROLLER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tcnt;
    // An accepted coin restarts the idle window, so it also masks the hit.
    assign tmo_hit = !coin_ok && tcnt == TW'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge clk) begin
        if (reset || cur != COLLECT || coin_ok)
            tcnt <= '0;
        else
            tcnt <= tcnt + 1'b1;
    end
`else
    // Never true; keeps the parameter referenced when the feature is absent.
    assign tmo_hit = TIMEOUT_CYCLES < 0;
`endif

    always_comb begin
        nxt        = cur;
        credit_nxt = credit;
        rej        = coin_valid;
        tmo        = 1'b0;
        case (cur)
            IDLE: begin
                credit_nxt = '0;
                if (selected_price != '0)
                    nxt = COLLECT;
            end
            COLLECT: begin
                rej        = coin_valid && !coin_ok;
                credit_nxt = sum;
                if (cancel)
                    nxt = REFUND;
                else if (sum >= price_ext)
                    nxt = DISPENSE;
                else if (tmo_hit) begin
                    nxt = REFUND;
                    tmo = 1'b1;
                end
            end
            DISPENSE: begin
                if (dcnt == DW'(DISPENSE_CYCLES - 1)) begin
                    nxt        = credit > price_ext ? CHANGE : IDLE;
                    credit_nxt = credit > price_ext ? credit : '0;
                end
            end
            CHANGE, REFUND: begin
                nxt        = IDLE;
                credit_nxt = '0;
            end
            default: begin
                nxt        = IDLE;
                credit_nxt = '0;
            end
        endcase
    end

    // Refund pulses only when there is something to return.
    assign pay = nxt == REFUND && credit_nxt != '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            cur          <= IDLE;
            credit       <= '0;
            price_reg    <= '0;
            dispense_id  <= 2'b00;
            dcnt         <= '0;
            dispense     <= 1'b0;
            change_valid <= 1'b0;
            change_amt   <= '0;
            refund       <= 1'b0;
            coin_reject  <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            cur          <= nxt;
            credit       <= credit_nxt;
            coin_reject  <= rej;
            dcnt         <= cur == DISPENSE ? dcnt + 1'b1 : '0;
            dispense     <= nxt == DISPENSE;
            change_valid <= nxt == CHANGE || pay;
            refund       <= pay;
            timeout      <= pay && tmo;
            if (cur == IDLE && selected_price != '0) begin
                price_reg   <= selected_price;
                dispense_id <= product_sel;
            end
            if (nxt == CHANGE)
                change_amt <= credit_nxt - price_ext;
            else if (pay)
                change_amt <= credit_nxt;
        end
    end
endmodule

// File: tb/tb_vending_controller.sv
// tb_vending_controller: directed table-driven bench for vending_controller.
module tb_vending_controller;
    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] product_sel;
    logic [4:0] selected_price;
    logic       coin_valid;
    logic [1:0] coin_code;
    logic       cancel;
    logic [5:0] credit;
    logic       dispense;
    logic [1:0] dispense_id;
    logic       change_valid;
    logic [5:0] change_amt;
    logic       refund;
    logic       coin_reject;
    logic       timeout;
    logic [2:0] state;

    int errs = 0;
    int checks = 0;

    always #5 clk = ~clk;

    vending_controller #(
        .PRICE_W(5), .CREDIT_W(6), .DISPENSE_CYCLES(2), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk), .reset(reset), .product_sel(product_sel),
        .selected_price(selected_price), .coin_valid(coin_valid),
        .coin_code(coin_code), .cancel(cancel), .credit(credit),
        .dispense(dispense), .dispense_id(dispense_id),
        .change_valid(change_valid), .change_amt(change_amt),
        .refund(refund), .coin_reject(coin_reject), .timeout(timeout),
        .state(state)
    );

    typedef struct {
        logic       r;
        logic [1:0] s;
        logic [4:0] p;
        logic       v;
        logic [1:0] c;
        logic       cn;
        logic [5:0] e_credit;
        logic       e_disp;
        logic [1:0] e_id;
        logic       e_cv;
        logic [5:0] e_amt;
        logic       e_ref;
        logic       e_rej;
        logic [2:0] e_st;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic [1:0] s, input logic [4:0] p,
                                input logic v, input logic [1:0] c, input logic cn,
                                input logic [5:0] ec, input logic ed, input logic [1:0] eid,
                                input logic ecv, input logic [5:0] ea, input logic er,
                                input logic erj, input logic [2:0] est);
        vec_t t;
        t.r = r; t.s = s; t.p = p; t.v = v; t.c = c; t.cn = cn;
        t.e_credit = ec; t.e_disp = ed; t.e_id = eid; t.e_cv = ecv;
        t.e_amt = ea; t.e_ref = er; t.e_rej = erj; t.e_st = est;
        return t;
    endfunction

    task automatic drive(input logic r, input logic [1:0] s, input logic [4:0] p,
                         input logic v, input logic [1:0] c, input logic cn);
        reset = r; product_sel = s; selected_price = p;
        coin_valid = v; coin_code = c; cancel = cn;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    initial begin
        drive(1, 0, 0, 0, 0, 0);
        //              r s  p  v c cn | crd d id cv amt rf rj st
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 15, 0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 2, 0, 10, 0, 1, 0,  0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 1, 0, 15, 1, 1, 0,  0, 0, 0, 2));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 15, 1, 1, 0,  0, 0, 0, 2));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 1, 0,  0, 0, 0, 0));
        vecs.push_back(mk(0, 3, 25, 0, 0, 0, 0, 0, 3, 0,  0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 3, 0, 20, 0, 3, 0,  0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 2, 0, 30, 1, 3, 0,  0, 0, 0, 2));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 30, 1, 3, 0,  0, 0, 0, 2));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 30, 0, 3, 1,  5, 0, 0, 3));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 3, 0,  5, 0, 0, 0));
        vecs.push_back(mk(0, 2, 20, 0, 0, 0, 0, 0, 2, 0,  5, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 2, 0, 10, 0, 2, 0,  5, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 10, 0, 2, 1, 10, 1, 0, 4));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 2, 0, 10, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 0,  0, 0, 2, 0, 10, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 2, 0, 10, 0, 0, 0));
        vecs.push_back(mk(0, 1, 15, 0, 0, 0, 0, 0, 1, 0, 10, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0,  0, 0, 1, 0, 10, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 10, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1,  0, 0, 1, 0, 10, 0, 0, 4));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 10, 0, 0, 0));
        vecs.push_back(mk(0, 2, 20, 0, 0, 0, 0, 0, 2, 0, 10, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 1, 0,  5, 0, 2, 0, 10, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 2, 1, 15, 0, 2, 1, 15, 1, 0, 4));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 2, 0, 15, 0, 0, 0));
        vecs.push_back(mk(0, 1, 15, 0, 0, 0, 0, 0, 1, 0, 15, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 3, 1, 20, 0, 1, 1, 20, 1, 0, 4));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 20, 0, 0, 0));
        vecs.push_back(mk(0, 3, 25, 0, 0, 0, 0, 0, 3, 0, 20, 0, 0, 1));
        vecs.push_back(mk(0, 1, 15, 1, 3, 0, 20, 0, 3, 0, 20, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 1, 0, 25, 1, 3, 0, 20, 0, 0, 2));
        vecs.push_back(mk(0, 0, 0, 1, 2, 1, 25, 1, 3, 0, 20, 0, 1, 2));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 3, 0, 20, 0, 0, 0));
        vecs.push_back(mk(0, 2, 20, 0, 0, 0, 0, 0, 2, 0, 20, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 2, 0, 10, 0, 2, 0, 20, 0, 0, 1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].r, vecs[i].s, vecs[i].p, vecs[i].v, vecs[i].c, vecs[i].cn);
            tick();
            chk($sformatf("vec%0d {crd,disp,id,cv,amt,ref,rej,tmo,st}", i),
                {10'd0, credit, dispense, dispense_id, change_valid, change_amt,
                 refund, coin_reject, timeout, state},
                {10'd0, vecs[i].e_credit, vecs[i].e_disp, vecs[i].e_id, vecs[i].e_cv,
                 vecs[i].e_amt, vecs[i].e_ref, vecs[i].e_rej, 1'b0, vecs[i].e_st});
        end

        // Dispense pulse width with exact payment: B (20) paid by one 20 coin.
        begin
            int n = 0;
            logic saw_cv = 1'b0;
            drive(0, 2, 20, 0, 0, 0);
            tick();
            drive(0, 0, 0, 1, 3, 0);
            tick();
            drive(0, 0, 0, 0, 0, 0);
            for (int i = 0; i < 8; i++) begin
                if (dispense) n++;
                saw_cv = saw_cv | change_valid;
                tick();
            end
            chk("disp_width", n, 2);
            chk("disp_no_change", {31'd0, saw_cv}, 0);
            chk("disp_id", {30'd0, dispense_id}, 2);
            chk("disp_credit_clear", {26'd0, credit}, 0);
            chk("disp_state_idle", {29'd0, state}, 0);
        end

`ifdef VENDING_CONTROLLER_TIMEOUT_EN
        // Select A, insert 5, then stay idle: refund after 8 idle cycles.
        drive(0, 1, 15, 0, 0, 0);
        tick();
        drive(0, 0, 0, 1, 1, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) tick();
        chk("tmo_before", {29'd0, state}, 1);
        tick();
        chk("tmo_state", {29'd0, state}, 4);
        chk("tmo_flags", {29'd0, change_valid, refund, timeout}, 3'b111);
        chk("tmo_amt", {26'd0, change_amt}, 5);
        tick();
        chk("tmo_idle", {29'd0, state}, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
